// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed in the start cycle and held in pending registers;
// a down-counter models the multi-cycle latency and commits at the end.
module e_mdu #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       MDUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] MDUout
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_p_q, hi_p_d;
  logic [WIDTH-1:0]   lo_p_q, lo_p_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Arithmetic results for the operands presented in the start cycle.
  logic [2*WIDTH-1:0] prod;
  logic               div_signed;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag;
  logic [WIDTH-1:0]   quo, rem;

  // Multiply and divide datapath; division works on magnitudes so the
  // MIN / -1 case wraps naturally to quotient MIN, remainder 0.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the block can leave a value unassigned and infer a latch.
    prod       = '0;
    div_signed = (MDUOp == MDU_DIV);
    a_neg      = div_signed & A[WIDTH-1];
    b_neg      = div_signed & B[WIDTH-1];
    a_mag      = a_neg ? -A : A;
    b_mag      = b_neg ? -B : B;
    q_mag      = '0;
    r_mag      = '0;

    if (MDUOp == MDU_MULT) begin
      prod = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
    end else begin
      prod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    end

    if (b_mag != '0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end

    // Quotient truncates toward zero; remainder follows the dividend's sign.
    quo = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem = a_neg ? -r_mag : r_mag;
  end

  // Next-state logic: accept operations in IDLE, count down and commit in BUSY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_p_d  = hi_p_q;
    lo_p_d  = lo_p_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (MDUOp)
            MDU_MULT, MDU_MULTU: begin
              hi_p_d  = prod[2*WIDTH-1:WIDTH];
              lo_p_d  = prod[WIDTH-1:0];
              cnt_d   = CNT_W'(MUL_CYCLES);
              state_d = ST_BUSY;
            end
            MDU_DIV, MDU_DIVU: begin
              // HI/LO cannot change while busy, so on divide-by-zero the
              // pending registers simply carry the current values through.
              if (B == '0) begin
                hi_p_d = hi_q;
                lo_p_d = lo_q;
              end else begin
                hi_p_d = rem;
                lo_p_d = quo;
              end
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = ST_BUSY;
            end
            MDU_MTHI: hi_d = A;
            MDU_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = hi_p_q;
          lo_d    = lo_p_q;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter, pending and architectural registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the pending registers are reset too; an aborted operation must
      // leave nothing behind that a later commit could pick up.
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_p_q  <= '0;
      lo_p_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_p_q  <= hi_p_d;
      lo_p_q  <= lo_p_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Combinational read port for mfhi/mflo.
  always_comb begin
    MDUout = '0;
    case (MDUOp)
      MDU_MFHI: MDUout = hi_q;
      MDU_MFLO: MDUout = lo_q;
      default:  MDUout = '0;
    endcase
  end

  assign busy = (state_q == ST_BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed and randomized checks of e_mdu at WIDTH=32 (default
// latencies) and WIDTH=16 (MUL_CYCLES=1, DIV_CYCLES=3) against a plain
// arithmetic reference model.
module tb_e_mdu;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        st32;
  logic [3:0]  op32;
  logic [31:0] a32, b32;
  logic        busy32;
  logic [31:0] hi32, lo32, out32;

  logic        st16;
  logic [3:0]  op16;
  logic [15:0] a16, b16;
  logic        busy16;
  logic [15:0] hi16, lo16, out16;

  e_mdu dut32 (
    .clk(clk), .reset(reset), .start(st32), .MDUOp(op32), .A(a32), .B(b32),
    .busy(busy32), .HI(hi32), .LO(lo32), .MDUout(out32)
  );

  e_mdu #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(3)) dut16 (
    .clk(clk), .reset(reset), .start(st16), .MDUOp(op16), .A(a16), .B(b16),
    .busy(busy16), .HI(hi16), .LO(lo16), .MDUout(out16)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected architectural HI/LO, index 0 = 32-bit unit, 1 = 16-bit unit.
  logic [31:0] exp_hi [2];
  logic [31:0] exp_lo [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit s16, input logic st, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (s16) begin
      st16 = st; op16 = op; a16 = a[15:0]; b16 = b[15:0];
    end else begin
      st32 = st; op32 = op; a32 = a; b32 = b;
    end
  endtask

  task automatic sample(input bit s16, output logic bz, output logic [31:0] hi,
                        output logic [31:0] lo, output logic [31:0] out);
    if (s16) begin
      bz = busy16; hi = {16'b0, hi16}; lo = {16'b0, lo16}; out = {16'b0, out16};
    end else begin
      bz = busy32; hi = hi32; lo = lo32; out = out32;
    end
  endtask

  // Reference: architectural effect of one accepted operation at width w.
  function automatic void model(input int w, input logic [3:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] hi, inout logic [31:0] lo);
    logic [63:0] mask, ua, ub, pu;
    longint      sa, sb, p, q, r;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'b0, a} & mask;
    ub   = {32'b0, b} & mask;
    sa   = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    sb   = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    case (op)
      4'd1: begin
        p  = sa * sb;
        hi = 32'((p >>> w) & mask);
        lo = 32'(p & mask);
      end
      4'd2: begin
        pu = ua * ub;
        hi = 32'((pu >> w) & mask);
        lo = 32'(pu & mask);
      end
      4'd3: if (ub != 0) begin
        q  = sa / sb;
        r  = sa % sb;
        lo = 32'(q & mask);
        hi = 32'(r & mask);
      end
      4'd4: if (ub != 0) begin
        lo = 32'((ua / ub) & mask);
        hi = 32'((ua % ub) & mask);
      end
      4'd7: hi = 32'(ua);
      4'd8: lo = 32'(ua);
      default: ;
    endcase
  endfunction

  function automatic int busy_len(input bit s16, input logic [3:0] op);
    if (op == 4'd1 || op == 4'd2) return s16 ? 1 : 5;
    if (op == 4'd3 || op == 4'd4) return s16 ? 3 : 10;
    return 0;
  endfunction

  function automatic logic [31:0] rand_val(input int w);
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0:       v = 32'h0;
      1:       v = 32'h1;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h1 << (w - 1);
      4:       v = 32'($urandom_range(0, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Issue one op, check busy timing, HI/LO hold while busy, commit, and MDUout.
  task automatic run_op(input bit s16, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit noise, input string tag);
    logic        bz;
    logic [31:0] hi, lo, out, nh, nl;
    int          n;
    nh = exp_hi[s16];
    nl = exp_lo[s16];
    model(s16 ? 16 : 32, op, a, b, nh, nl);
    n = busy_len(s16, op);

    drive(s16, 1'b1, op, a, b);
    #1;
    sample(s16, bz, hi, lo, out);
    check({tag, ".busy_in_start_cycle"}, 64'(bz), 64'd0);
    @(posedge clk); #1;
    drive(s16, 1'b0, 4'd0, $urandom, $urandom);

    for (int j = 0; j < n; j++) begin
      sample(s16, bz, hi, lo, out);
      check({tag, ".busy"}, 64'(bz), 64'd1);
      check({tag, ".hi_hold"}, 64'(hi), 64'(exp_hi[s16]));
      check({tag, ".lo_hold"}, 64'(lo), 64'(exp_lo[s16]));
      if (noise) begin
        case (j)
          0:       drive(s16, 1'b1, 4'd8, 32'hAAAA, $urandom);
          1:       drive(s16, 1'b1, 4'd2, 32'd7, 32'd7);
          default: drive(s16, 1'b1, 4'($urandom_range(1, 8)), $urandom, $urandom);
        endcase
      end else begin
        drive(s16, 1'b0, 4'd0, $urandom, $urandom);
      end
      @(posedge clk); #1;
    end

    drive(s16, 1'b0, 4'd0, 32'd0, 32'd0);
    sample(s16, bz, hi, lo, out);
    check({tag, ".busy_done"}, 64'(bz), 64'd0);
    check({tag, ".hi"}, 64'(hi), 64'(nh));
    check({tag, ".lo"}, 64'(lo), 64'(nl));
    exp_hi[s16] = nh;
    exp_lo[s16] = nl;

    drive(s16, 1'b0, 4'd5, 32'd0, 32'd0); #1;
    sample(s16, bz, hi, lo, out);
    check({tag, ".mfhi"}, 64'(out), 64'(nh));
    drive(s16, 1'b0, 4'd6, 32'd0, 32'd0); #1;
    sample(s16, bz, hi, lo, out);
    check({tag, ".mflo"}, 64'(out), 64'(nl));
    drive(s16, 1'b0, 4'd0, 32'd0, 32'd0); #1;
    sample(s16, bz, hi, lo, out);
    check({tag, ".mdu_none_out"}, 64'(out), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    logic        bz;
    logic [31:0] hi, lo, out;
    for (int s = 0; s < 2; s++) begin
      sample(s[0], bz, hi, lo, out);
      check({tag, ".busy"}, 64'(bz), 64'd0);
      check({tag, ".hi"}, 64'(hi), 64'd0);
      check({tag, ".lo"}, 64'(lo), 64'd0);
    end
  endtask

  initial begin
    logic [3:0] rop;
    reset = 1'b0;
    drive(1'b0, 1'b0, 4'd5, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 4'd5, 32'd0, 32'd0);
    exp_hi[0] = '0; exp_lo[0] = '0;
    exp_hi[1] = '0; exp_lo[1] = '0;
    #12;
    check_all_zero("reset");
    check("reset.mfhi32", 64'(out32), 64'd0);
    reset = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    @(posedge clk); #1;

    // Directed cases at WIDTH=32.
    run_op(1'b0, 4'd1, 32'hFFFF_FFFD, 32'd5,         1'b0, "mult_neg3x5");
    run_op(1'b0, 4'd4, 32'hFFFF_FFFF, 32'h10,        1'b0, "divu");
    run_op(1'b0, 4'd3, 32'hFFFF_FFF9, 32'd2,         1'b0, "div_neg7by2");
    run_op(1'b0, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_min_by_m1");
    run_op(1'b0, 4'd7, 32'h1234,      32'd0,         1'b0, "mthi");
    run_op(1'b0, 4'd8, 32'h5678,      32'd0,         1'b0, "mtlo");
    run_op(1'b0, 4'd3, 32'hDEAD_BEEF, 32'd0,         1'b0, "div_by_zero");
    run_op(1'b0, 4'd2, 32'd2,         32'd3,         1'b1, "multu_ignored_starts");
    run_op(1'b0, 4'd5, 32'hFFFF,      32'hFFFF,      1'b0, "mfhi_with_start");
    run_op(1'b0, 4'd12, 32'hFFFF,     32'hFFFF,      1'b0, "op12_with_start");

    // Directed cases at WIDTH=16.
    run_op(1'b1, 4'd1, 32'h8000, 32'h8000, 1'b0, "p16_mult");
    run_op(1'b1, 4'd4, 32'd9,    32'd4,    1'b0, "p16_divu");

    // Reset in the middle of busy cycle 4 of a divide aborts it for good.
    drive(1'b0, 1'b1, 4'd3, 32'd100, 32'd7);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    exp_hi[0] = '0; exp_lo[0] = '0;
    exp_hi[1] = '0; exp_lo[1] = '0;
    check_all_zero("reset_mid_op");
    reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check_all_zero("no_commit_after_reset");

    // Randomized operations on both instances.
    for (int i = 0; i < 80; i++) begin
      bit s16;
      s16 = i[0];
      if ($urandom_range(0, 3) == 0) rop = 4'($urandom_range(0, 15));
      else                          rop = 4'($urandom_range(1, 4));
      if ($urandom_range(0, 5) == 0) rop = 4'($urandom_range(7, 8));
      run_op(s16, rop, rand_val(s16 ? 16 : 32), rand_val(s16 ? 16 : 32),
             1'($urandom_range(0, 1)), s16 ? "rand16" : "rand32");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
# e_mdu

Parametrised multi-cycle multiply/divide unit for the Execute stage, next to the ALU. It provides signed and unsigned multiply and divide, with results held in architectural HI/LO registers. It also provides the HI/LO move instructions. It raises `busy` so the hazard unit can stall dependent instructions while an operation is in flight.

## Interface
Parameters:
- `WIDTH`, 32: operand, HI and LO width.
- `MUL_CYCLES`, 5: busy cycles for mult/multu; must be ≥ 1.
- `DIV_CYCLES`, 10: busy cycles for div/divu; must be ≥ 1.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: qualifies `MDUOp` in the current cycle.
- `MDUOp`  in  4: operation code, defined in const.v. `MDU_none`=0, `MDU_mult`=1, `MDU_multu`=2, `MDU_div`=3, `MDU_divu`=4, `MDU_mfhi`=5, `MDU_mflo`=6, `MDU_mthi`=7, `MDU_mtlo`=8.
- `A`  in  WIDTH: operand rs (dividend / multiplicand / mthi/mtlo source).
- `B`  in  WIDTH: operand rt (divisor / multiplier).
- `busy`  out  1: operation in flight.
- `HI`  out  WIDTH: HI register.
- `LO`  out  WIDTH: LO register.
- `MDUout`  out  WIDTH: combinational read port for mfhi/mflo.

## Operation
- States: IDLE and BUSY. The down-counter `cnt` is internal.
- **IDLE, start with mult/multu/div/divu:**
  - Compute the result from the current A/B and latch it into pending registers `hi_p`/`lo_p`.
  - Load `cnt` with MUL_CYCLES or DIV_CYCLES and go to BUSY.
  - A and B are don't-care after the start cycle.
- **IDLE, start with mthi/mtlo:** write A into HI or LO at the edge. No busy.
- **mfhi/mflo and codes 0 or 9–15 with start:** no state change.
- **BUSY:** decrement `cnt` each cycle. When `cnt` reaches 1, commit `hi_p`→HI and `lo_p`→LO at that edge and return to IDLE.
- **start in BUSY (any op, including mthi/mtlo):** ignored. The stall logic must not issue it.
- **mult:** signed 2·WIDTH-bit product. HI = upper WIDTH bits, LO = lower WIDTH bits.
- **multu:** same as mult, unsigned.
- **div:** signed. LO = quotient truncated toward zero. HI = remainder, which takes the sign of the dividend.
  - MIN/−1 gives LO = MIN, HI = 0.
- **divu:** unsigned quotient/remainder.
- **Divide by zero (div/divu with B = 0):** full DIV_CYCLES busy period still runs. HI and LO stay unchanged at commit.
- **MDUout:**
  - `MDUOp`==`MDU_mfhi` → HI.
  - `MDUOp`==`MDU_mflo` → LO.
  - Otherwise 0.
  - Independent of `start` and `busy`, and reflects the current register values.

## Timing
- **Reset (reset=0, asynchronous):** HI=0, LO=0, busy=0, cnt=0, pending registers=0. State goes to IDLE immediately without waiting for a clock edge.
  - A reset mid-operation aborts it. No commit occurs.
- **Start at edge k (N = MUL_CYCLES or DIV_CYCLES):**
  - `busy` is 1 after edge k through edge k+N.
  - HI/LO take their new values at edge k+N, and `busy` falls at that same edge.
  - A new start is accepted at edge k+N+1 at the earliest.
- `busy` is registered and is 0 in the start cycle itself. The hazard unit stalls on `start | busy`.
- mthi/mtlo: new value is visible on HI/LO and MDUout one edge after the start cycle.
- MDUout: zero-cycle combinational path from MDUOp, HI and LO.

## Test plan
- **Signed multiply:** reset, then start mult with A=0xFFFFFFFD (−3), B=5. Expect `busy` high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1. During busy, HI/LO must stay 0.
- **Unsigned divide and signed divide:**
  - divu A=0xFFFFFFFF, B=0x10 → after 10 busy cycles, LO=0x0FFFFFFF, HI=0x0000000F.
  - div A=0xFFFFFFF9 (−7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - div A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- **Divide by zero:** mthi 0x1234, mtlo 0x5678, then div B=0. Expect busy for 10 cycles, then HI=0x1234 and LO=0x5678 unchanged. mfhi gives MDUout=0x1234.
- **Ignored starts and held operands:** start multu 2×3. While busy, issue mtlo 0xAAAA and multu 7×7, and change A/B every cycle. Expect a single commit with HI=0, LO=6, and busy deasserting at cycle 5.
- **Reset mid-operation:** start div 100/7, and pulse reset=0 asynchronously mid-cycle at busy cycle 4. Expect busy=0, HI=LO=0 immediately, and no later commit.
- **Parametrisation:** with WIDTH=16, MUL_CYCLES=1, DIV_CYCLES=3, run mult 0x8000×0x8000. Expect HI=0x4000, LO=0 after 1 busy cycle, and divu 9/4 to give LO=2, HI=1 after 3 cycles.
